// File: rtl/decode_rom_loader_if.sv
// Handshake and ROM-port bundle between the host byte source, the loader and the decode ROM.
interface decode_rom_loader_if;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  rom_addr;
  logic [43:0] rom_data;
  logic        rom_we;
  logic [43:0] rom_q;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [9:0]  err_addr;

  // Environment side: host byte source, control logic and ROM read data.
  modport master (
    output start, base_addr, word_count, in_data, in_valid, rom_q,
    input  in_ready, rom_addr, rom_data, rom_we, busy, done, err_code, err_addr
  );

  // Loader side.
  modport slave (
    input  start, base_addr, word_count, in_data, in_valid, rom_q,
    output in_ready, rom_addr, rom_data, rom_we, busy, done, err_code, err_addr
  );
endinterface

// File: rtl/decode_rom_loader.sv
// Decode ROM loader: assembles 44-bit words from a byte stream, writes each
// into the ROM, reads it back and verifies it. Reports done and first error.
module decode_rom_loader #(
  parameter int BYTES_PER_WORD = 6
) (
  input logic clk,
  input logic rst,
  decode_rom_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, READ, CHECK, DONE} state_t;

  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_WORD - 1);

  state_t      state;
  logic [9:0]  addr;
  logic [10:0] remaining;
  logic [2:0]  byte_cnt;
  logic [43:0] word;

  // Session FSM; every output is registered and set on the edge entering its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      remaining    <= '0;
      byte_cnt     <= '0;
      word         <= '0;
      bus.in_ready <= 1'b0;
      bus.rom_addr <= '0;
      bus.rom_data <= '0;
      bus.rom_we   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err_code <= '0;
      bus.err_addr <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.rom_we <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            addr         <= bus.base_addr;
            remaining    <= (bus.word_count > 11'd1024) ? 11'd1024 : bus.word_count;
            byte_cnt     <= '0;
            bus.err_code <= '0;
            bus.err_addr <= '0;
            if (bus.word_count == 11'd0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state        <= COLLECT;
              bus.in_ready <= 1'b1;
              bus.busy     <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.in_valid && bus.in_ready) begin
            if (byte_cnt == LAST_BYTE) begin
              bus.in_ready <= 1'b0;
              if (bus.in_data[7:4] != 4'h0) begin
                // Only the low nibble of the top byte is meaningful; anything else is a framing fault.
                bus.err_code <= 2'd1;
                bus.err_addr <= addr;
                bus.busy     <= 1'b0;
                bus.done     <= 1'b1;
                state        <= DONE;
              end else begin
                // The final nibble bypasses the word register so the write can start next cycle.
                word[43:40]  <= bus.in_data[3:0];
                bus.rom_data <= {bus.in_data[3:0], word[39:0]};
                bus.rom_addr <= addr;
                bus.rom_we   <= 1'b1;
                state        <= WRITE;
              end
            end else begin
              word[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        WRITE: begin
          // Keep the address up for one more cycle so the ROM registers the read.
          bus.rom_addr <= addr;
          state        <= READ;
        end
        READ: begin
          state <= CHECK;
        end
        CHECK: begin
          if (bus.rom_q != word) begin
            bus.err_code <= 2'd2;
            bus.err_addr <= addr;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end else begin
            remaining <= remaining - 11'd1;
            addr      <= addr + 10'd1;
            byte_cnt  <= '0;
            if (remaining == 11'd1) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              bus.in_ready <= 1'b1;
              state        <= COLLECT;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_rom_loader.sv
// Bench for decode_rom_loader: table-driven sessions, randomized sessions and
// hand-written reset sequences, checked against a word-level session model.
module tb_decode_rom_loader;

  localparam int LIMIT = 12000;
  localparam logic [43:0] FLIP = 44'h800_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_rom_loader_if bus();
  decode_rom_loader #(.BYTES_PER_WORD(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ROM model: synchronous write, registered read address, optional bit-43 corruption on read.
  logic [43:0] mem [0:1023];
  logic [43:0] q;
  bit          flip_en;
  logic [9:0]  flip_a;
  always @(posedge clk) begin
    if (bus.rom_we) mem[bus.rom_addr] <= bus.rom_data;
    q <= mem[bus.rom_addr] ^ ((flip_en && bus.rom_addr == flip_a) ? FLIP : 44'h0);
  end
  assign bus.rom_q = q;

  typedef struct packed { logic [9:0] a; logic [43:0] d; } wr_t;

  typedef struct {
    logic [9:0]  base;
    int          count;
    int          fmt_idx;    // word index carrying a bad top byte, -1 none
    int          flip;       // ROM address read back corrupted, -1 none
    bit          gap;        // in_valid only every other cycle
    int          restart_at; // loop cycle for a stray start pulse, -1 none
    logic [43:0] w0;         // fixed first word, 0 = random
    bit          has_exp;
    logic [1:0]  exp_err;
    logic [9:0]  exp_ea;
    int          exp_wr;
    int          exp_done;   // session cycle of done, -1 don't care
    int          exp_we;     // session cycle of first rom_we, -1 don't care
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  wr_t obs_wr[$];
  int  obs_done_cyc, obs_we_cyc;
  bit  obs_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Session reference: walks words in order, stopping at the first framing or verify fault.
  task automatic model(input logic [9:0] base, input int count, input logic [43:0] words[$],
                       input int fmt_idx, input int flip,
                       output wr_t exp_wr[$], output logic [1:0] e, output logic [9:0] ea);
    int n;
    n = (count > 1024) ? 1024 : count;
    e = 2'd0; ea = 10'd0; exp_wr = {};
    for (int i = 0; i < n; i++) begin
      logic [9:0] a;
      a = 10'((int'(base) + i) % 1024);
      if (i == fmt_idx) begin e = 2'd1; ea = a; break; end
      exp_wr.push_back({a, words[i]});
      if (flip >= 0 && int'(a) == flip) begin e = 2'd2; ea = a; break; end
    end
  endtask

  // Drives one session; returns at the negedge of the done cycle (cycle numbers from start edge).
  task automatic run(input logic [9:0] base, input int count, input logic [7:0] bytes[$],
                     input bit gap, input int restart_at);
    int idx = 0;
    int cyc = 0;
    bit got = 0;
    bit xfer;
    obs_wr = {}; obs_done_cyc = -1; obs_we_cyc = -1; obs_busy = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = base; bus.word_count = 11'(count);
    @(negedge clk);
    bus.start = 1'b0;
    while (!got && cyc < LIMIT) begin
      bus.start      = (cyc == restart_at);
      bus.base_addr  = (cyc == restart_at) ? ~base : base;
      bus.word_count = (cyc == restart_at) ? 11'd5 : 11'(count);
      if (bus.busy) obs_busy = 1;
      if (bus.rom_we) begin
        obs_wr.push_back({bus.rom_addr, bus.rom_data});
        if (obs_we_cyc < 0) obs_we_cyc = cyc + 1;
      end
      if (bus.done) begin got = 1; obs_done_cyc = cyc + 1; end
      bus.in_valid = !got && idx < bytes.size() && (!gap || cyc % 2 == 0);
      bus.in_data  = (idx < bytes.size()) ? bytes[idx] : 8'h00;
      xfer = bus.in_valid && bus.in_ready;
      if (!got) begin
        @(negedge clk);
        if (xfer) idx++;
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("session_done_seen", 64'(got), 64'd1);
  endtask

  task automatic do_case(input string name, input vec_t v);
    logic [43:0] words[$];
    logic [7:0]  bytes[$];
    wr_t         exp_wr[$];
    logic [1:0]  e;
    logic [9:0]  ea;
    int          n;
    bit          ok;
    n = (v.count > 1024) ? 1024 : v.count;
    for (int i = 0; i < n; i++) begin
      logic [43:0] w;
      w = (i == 0 && v.w0 != 44'h0) ? v.w0 : 44'({$urandom(), $urandom()});
      words.push_back(w);
      for (int k = 0; k < 5; k++) bytes.push_back(w[8*k +: 8]);
      bytes.push_back((i == v.fmt_idx) ? 8'h1F : {4'h0, w[43:40]});
    end
    model(v.base, v.count, words, v.fmt_idx, v.flip, exp_wr, e, ea);
    flip_en = (v.flip >= 0);
    flip_a  = 10'(v.flip);
    run(v.base, v.count, bytes, v.gap, v.restart_at);
    chk({name, "_rdy_at_done"}, 64'(bus.in_ready), 64'd0);
    chk({name, "_busy_seen"}, 64'(obs_busy), 64'(v.count != 0));
    chk({name, "_nwrites"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    ok = (obs_wr.size() == exp_wr.size());
    for (int i = 0; i < obs_wr.size() && ok; i++) ok = (obs_wr[i] == exp_wr[i]);
    chk({name, "_write_stream"}, 64'(ok), 64'd1);
    @(negedge clk);
    chk({name, "_done_1cyc"}, 64'(bus.done), 64'd0);
    chk({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    chk({name, "_err_code"}, 64'(bus.err_code), 64'(e));
    chk({name, "_err_addr"}, 64'(bus.err_addr), 64'(ea));
    if (v.has_exp) begin
      chk({name, "_tbl_err"}, 64'(bus.err_code), 64'(v.exp_err));
      chk({name, "_tbl_eaddr"}, 64'(bus.err_addr), 64'(v.exp_ea));
      chk({name, "_tbl_nwr"}, 64'(obs_wr.size()), 64'(v.exp_wr));
      if (v.exp_done >= 0) chk({name, "_done_cycle"}, 64'(obs_done_cyc), 64'(v.exp_done));
      if (v.exp_we >= 0) chk({name, "_we_cycle"}, 64'(obs_we_cyc), 64'(v.exp_we));
      if (v.w0 != 44'h0 && obs_wr.size() > 0) chk({name, "_word0"}, 64'(obs_wr[0].d), 64'(v.w0));
    end
    flip_en = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
    chk({tag, "_rom_data"}, 64'(bus.rom_data), 64'd0);
    chk({tag, "_rom_we"},   64'(bus.rom_we), 64'd0);
    chk({tag, "_busy"},     64'(bus.busy), 64'd0);
    chk({tag, "_done"},     64'(bus.done), 64'd0);
    chk({tag, "_err_code"}, 64'(bus.err_code), 64'd0);
    chk({tag, "_err_addr"}, 64'(bus.err_addr), 64'd0);
  endtask

  function automatic vec_t mk(input logic [9:0] base, input int count, input int fmt_idx,
                              input int flip, input bit gap, input int restart_at,
                              input logic [43:0] w0, input logic [1:0] exp_err,
                              input logic [9:0] exp_ea, input int exp_wr,
                              input int exp_done, input int exp_we);
    vec_t v;
    v.base = base; v.count = count; v.fmt_idx = fmt_idx; v.flip = flip; v.gap = gap;
    v.restart_at = restart_at; v.w0 = w0; v.has_exp = 1; v.exp_err = exp_err;
    v.exp_ea = exp_ea; v.exp_wr = exp_wr; v.exp_done = exp_done; v.exp_we = exp_we;
    return v;
  endfunction

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(10'h010, 1,    -1, -1,  0, -1, 44'hA8967452301, 2'd0, 10'h000, 1,    10, 7);
    vecs[1] = mk(10'h3FF, 2,    -1, -1,  1, -1, 44'h0,           2'd0, 10'h000, 2,    -1, -1);
    vecs[2] = mk(10'h100, 4,     2, -1,  0, -1, 44'h0,           2'd1, 10'h102, 2,    -1, -1);
    vecs[3] = mk(10'h000, 10,   -1,  5,  0, -1, 44'h0,           2'd2, 10'h005, 6,    -1, -1);
    vecs[4] = mk(10'h020, 3,    -1, -1,  0,  5, 44'h0,           2'd0, 10'h000, 3,    28, -1);
    vecs[5] = mk(10'h055, 0,    -1, -1,  0, -1, 44'h0,           2'd0, 10'h000, 0,    1,  -1);
    vecs[6] = mk(10'h200, 1500, -1, -1,  0, -1, 44'h0,           2'd0, 10'h000, 1024, -1, -1);
    vecs[7] = mk(10'h3FF, 2,     0, -1,  0, -1, 44'h0,           2'd1, 10'h3FF, 0,    7,  -1);
    vecs[8] = mk(10'h3FE, 3,    -1,  0,  0, -1, 44'h0,           2'd2, 10'h000, 3,    28, -1);

    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    bus.in_data = '0; bus.in_valid = 1'b0;
    flip_en = 0; flip_a = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;

    foreach (vecs[i]) do_case($sformatf("vec%0d", i), vecs[i]);

    // Randomized sessions, expectations from the model only.
    for (int r = 0; r < 20; r++) begin
      vec_t v;
      v.base = 10'($urandom_range(0, 1023));
      v.count = $urandom_range(1, 8);
      v.fmt_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v.count - 1) : -1;
      v.flip = ($urandom_range(0, 3) == 0)
               ? (int'(v.base) + $urandom_range(0, v.count - 1)) % 1024 : -1;
      v.gap = 1'($urandom_range(0, 1));
      v.restart_at = -1; v.w0 = 44'h0; v.has_exp = 0;
      v.exp_err = '0; v.exp_ea = '0; v.exp_wr = 0; v.exp_done = -1; v.exp_we = -1;
      do_case($sformatf("rnd%0d", r), v);
    end

    // Reset during COLLECT of the second word, then a clean session.
    begin
      int acc = 0;
      int c = 0;
      bit xfer;
      vec_t v;
      @(negedge clk);
      bus.start = 1'b1; bus.base_addr = 10'h040; bus.word_count = 11'd3;
      @(negedge clk);
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      while (acc < 8 && c < 60) begin
        bus.in_data = 8'(acc);
        xfer = bus.in_ready;
        @(negedge clk);
        if (xfer) acc++;
        c++;
      end
      bus.in_valid = 1'b0;
      chk("prerst_bytes", 64'(acc), 64'd8);
      chk("prerst_busy", 64'(bus.busy), 64'd1);
      chk("prerst_in_ready", 64'(bus.in_ready), 64'd1);
      #2 rst = 1'b1;
      #1 chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      v = mk(10'h080, 2, -1, -1, 0, -1, 44'h0, 2'd0, 10'h000, 2, 19, 7);
      do_case("post_rst", v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_rom_loader.md
# decode_rom_loader

Loads microcode into the 1024 x 44-bit decode ROM through its write port (address, data, write enable) from a byte stream, such as a UART or debug-bridge receiver. After each write it reads the word back and checks it. The block sits between the host byte source and the decode ROM, and owns the ROM write port while a load session runs. It reports completion, or the first failing address, to the control/status logic.

## Interface
Parameters:
- BYTES_PER_WORD, 6: bytes assembled into one 44-bit word. Fixed at 6; other values are unsupported.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load session; ignored unless IDLE
- base_addr  in  10  first ROM address of the session; sampled on start
- word_count  in  11  number of words, 0..1024; values >1024 treated as 1024; sampled on start
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle; transfer when in_valid && in_ready
- rom_addr  out  10  ROM address
- rom_data  out  44  ROM write data
- rom_we  out  1  ROM write enable
- rom_q  in  44  ROM read data; address is registered inside the ROM, so data is valid one cycle after rom_addr is presented
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end, whether it ended with success or error
- err_code  out  2  0 none, 1 format error, 2 verify mismatch; held until next accepted start
- err_addr  out  10  ROM address of the failing word; held with err_code

## Operation
- States: IDLE, COLLECT, WRITE, READ, CHECK, DONE.
- IDLE: in_ready=0, rom_we=0. On start:
  - latch addr=base_addr and remaining=min(word_count,1024);
  - clear err_code and err_addr;
  - go to DONE if remaining is 0, otherwise go to COLLECT.
- COLLECT: in_ready=1. Accepted bytes fill the word little-endian: byte k goes to bits [8k+7:8k]. Byte 5 supplies bits [43:40] from in_data[3:0].
  - If byte 5 has in_data[7:4] != 0: set err_code=1, err_addr=addr, go to DONE.
  - Otherwise, once the 6th byte is accepted, go to WRITE.
- WRITE: rom_we=1, rom_addr=addr, rom_data=word. Go to READ.
- READ: rom_we=0, rom_addr=addr. Go to CHECK.
- CHECK: compare rom_q against the held word.
  - Mismatch: err_code=2, err_addr=addr, go to DONE.
  - Match: decrement remaining and set addr=addr+1, modulo 1024, so 1023 wraps to 0.
  - Then go to DONE if remaining is now 0, otherwise go to COLLECT with the byte counter reset.
- DONE: done=1 for this single cycle, then go to IDLE.
- The ROM port is driven only in WRITE, READ and CHECK. In all other states rom_we=0, and rom_addr/rom_data hold their last values.
- busy=1 in COLLECT, WRITE, READ and CHECK; busy=0 in IDLE and DONE.
- in_valid gaps stall COLLECT with no timeout. Partial-word state is kept across gaps.
- A start pulse arriving in any non-IDLE state is ignored and has no side effect.

## Timing
- Reset values: state IDLE, in_ready=0, rom_addr=0, rom_data=0, rom_we=0, busy=0, done=0, err_code=0, err_addr=0. Byte counter, word register and remaining are also cleared.
- Reset asserted mid-session aborts it immediately. If the reset overlaps a WRITE cycle, rom_we drops asynchronously with reset; the word at that address is then undefined.
- Session cycle numbering, with start sampled at edge 0:
  - COLLECT (in_ready=1) from cycle 1;
  - with back-to-back bytes, bytes accepted in cycles 1-6;
  - WRITE in cycle 7, READ in cycle 8, CHECK in cycle 9;
  - the next word's COLLECT starts in cycle 10, or the final done pulses in cycle 10.
- Per-word cost: 6 byte cycles + 3 cycles, so 9 cycles/word at full stream rate.
- word_count=0: done pulses in cycle 1, busy is never asserted, and no ROM access occurs.
- Format error: detected in the cycle byte 5 is accepted; done pulses the next cycle; no write is issued for that word.
- err_code and err_addr update on the same edge that enters DONE.

## Test plan
- Single word: start with base_addr=0x010, word_count=1; send bytes 0x01,0x23,0x45,0x67,0x89,0x0A back-to-back. Required: rom_we high for exactly 1 cycle (cycle 7) with rom_addr=0x010 and rom_data=0xA8967452301; done in cycle 10; err_code=0.
- Wrap and backpressure: base_addr=0x3FF, word_count=2, with in_valid toggled every other cycle. Required: writes land at 0x3FF then 0x000; in_ready stays high through the gaps; the partial word is preserved across gaps; err_code=0.
- Format error: byte 5 = 0x1F on the 3rd word of a 4-word session at base 0x100. Required: err_code=1, err_addr=0x102; only 2 write pulses occur; done pulses once.
- Verify mismatch: the ROM model flips rom_q bit 43 at address 0x005 during a 10-word session from 0x000. Required: err_code=2, err_addr=0x005; exactly 6 write pulses; no further in_ready after the failing CHECK.
- Control edges: pulse start again while busy. Required: no effect. word_count=0. Required: done in cycle 1 with no rom_we. word_count=1500. Required: exactly 1024 writes.
- Reset mid-session: assert rst during COLLECT of word 2. Required: all outputs at reset values immediately; a subsequent start runs a clean session from its own base_addr.
